// File: rtl/firc_out_buf.sv
// firc_out_buf: output stage behind the complex FIR (firc).
// Each FI/FQ result is rounded half-up and shifted right by SHIFT, then fitted to OW bits.
// The fitted pair is buffered in a DEPTH-entry FIFO that drains under PushOut/StopOut flow control.
// firc cannot be stalled, so a write that meets a full FIFO is dropped and counted in DropCnt.
// Build option FIRC_OUT_SAT_EN:
//   defined   -> an out-of-range rounded value saturates to the OW limits.
//   undefined -> an out-of-range rounded value wraps to its low OW bits.
// Ovf is sticky and is flagged in both builds.
module firc_out_buf #(
  parameter int IW    = 32,
  parameter int OW    = 16,
  parameter int SHIFT = 16,
  parameter int DEPTH = 8
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     PushIn,
  input  logic [IW-1:0]            FI,
  input  logic [IW-1:0]            FQ,
  input  logic                     StopOut,
  output logic                     PushOut,
  output logic [OW-1:0]            OutI,
  output logic [OW-1:0]            OutQ,
  output logic [$clog2(DEPTH):0]   Level,
  output logic [7:0]               DropCnt,
  output logic                     Ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int XW = IW + 1;
  localparam logic signed [XW-1:0] HALF = {{(XW-1){1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ZERO_LVL = {(AW + 1){1'b0}};

  // Sign-extend by one bit so that adding the rounding constant can never overflow.
  function automatic logic signed [XW-1:0] roundShift(input logic [IW-1:0] x);
    logic signed [XW-1:0] sum;
    sum = $signed({x[IW-1], x}) + HALF;
    return sum >>> SHIFT;
  endfunction

  // A value fits in OW signed bits only when every bit above OW-1 equals the sign bit.
  function automatic logic outOfRange(input logic signed [XW-1:0] r);
    return !((&r[XW-1:OW-1]) || !(|r[XW-1:OW-1]));
  endfunction

  // Narrow a rounded value to OW bits.
  function automatic logic [OW-1:0] fitOut(input logic signed [XW-1:0] r);
`ifdef FIRC_OUT_SAT_EN
    logic [OW-1:0] y;
    if (!outOfRange(r)) begin
      y = r[OW-1:0];
    end else if (r[XW-1]) begin
      y = {1'b1, {(OW-1){1'b0}}};
    end else begin
      y = {1'b0, {(OW-1){1'b1}}};
    end
    return y;
`else
    return r[OW-1:0];
`endif
  endfunction

  logic signed [XW-1:0] rI;
  logic signed [XW-1:0] rQ;
  logic                 s1Valid;
  logic [OW-1:0]        s1I;
  logic [OW-1:0]        s1Q;
  logic [2*OW-1:0]      mem [DEPTH];
  logic [AW-1:0]        wrPtr;
  logic [AW-1:0]        rdPtr;
  logic                 pop;
  logic                 wrEn;
  logic                 drop;
  logic [2*OW-1:0]      headData;

  // Round both incoming components.
  always_comb begin
    rI = roundShift(FI);
    rQ = roundShift(FQ);
  end

  // Stage 1: register the fitted sample pair and its valid flag.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1Valid <= 1'b0;
      s1I     <= {OW{1'b0}};
      s1Q     <= {OW{1'b0}};
    end else begin
      s1Valid <= PushIn;
      if (PushIn) begin
        s1I <= fitOut(rI);
        s1Q <= fitOut(rQ);
      end
    end
  end

  // Sticky overflow flag, set alongside the stage-1 register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Ovf <= 1'b0;
    end else if (PushIn && (outOfRange(rI) || outOfRange(rQ))) begin
      Ovf <= 1'b1;
    end
  end

  // FIFO control. A pop frees a slot in the same cycle, so a write at full is accepted when a pop also occurs.
  always_comb begin
    pop  = (Level != ZERO_LVL) && !StopOut;
    wrEn = s1Valid && ((Level != FULL_LVL) || pop);
    drop = s1Valid && (Level == FULL_LVL) && !pop;
  end

  // FIFO storage. It is not reset: Level and the pointers determine which entries are valid.
  always_ff @(posedge Clk) begin
    if (wrEn) begin
      mem[wrPtr] <= {s1I, s1Q};
    end
  end

  // Pointers wrap modulo DEPTH. DEPTH is a power of 2, so natural overflow provides the wrap.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wrPtr <= {AW{1'b0}};
      rdPtr <= {AW{1'b0}};
    end else begin
      if (wrEn) begin
        wrPtr <= wrPtr + AW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + AW'(1);
      end
    end
  end

  // Occupancy counter: it is unchanged when a write and a pop coincide.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Level <= ZERO_LVL;
    end else begin
      case ({wrEn, pop})
        2'b10:   Level <= Level + (AW + 1)'(1);
        2'b01:   Level <= Level - (AW + 1)'(1);
        default: Level <= Level;
      endcase
    end
  end

  // Count of dropped samples, holding at 255.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      DropCnt <= 8'd0;
    end else if (drop && (DropCnt != 8'hFF)) begin
      DropCnt <= DropCnt + 8'd1;
    end
  end

  // Read side. Outputs show the FIFO head, and read as zero while the FIFO is empty.
  always_comb begin
    PushOut = pop;
    if (Level != ZERO_LVL) begin
      headData = mem[rdPtr];
    end else begin
      headData = {(2*OW){1'b0}};
    end
    OutI = headData[2*OW-1:OW];
    OutQ = headData[OW-1:0];
  end

endmodule

// File: tb/tb_firc_out_buf.sv
// Self-checking bench for firc_out_buf.
// The reference model rounds samples with integer floor division and keeps the FIFO as a queue.
// Define FIRC_OUT_SAT_EN for both the bench and the design to check the saturating build.
module tb_firc_out_buf;
  localparam int IW = 32, OW = 16, SHIFT = 16, DEPTH = 8;
  localparam int LW = $clog2(DEPTH) + 1;

  logic          Clk = 1'b0;
  logic          Reset, PushIn, StopOut;
  logic [IW-1:0] FI, FQ;
  logic          PushOut, Ovf;
  logic [OW-1:0] OutI, OutQ;
  logic [LW-1:0] Level;
  logic [7:0]    DropCnt;

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [2*OW-1:0] q[$];
  logic            pendV;
  logic [2*OW-1:0] pendD;
  int              dropE;
  logic            ovfE;

  firc_out_buf #(.IW(IW), .OW(OW), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset), .PushIn(PushIn), .FI(FI), .FQ(FQ), .StopOut(StopOut),
    .PushOut(PushOut), .OutI(OutI), .OutQ(OutQ), .Level(Level), .DropCnt(DropCnt), .Ovf(Ovf)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Rounded value floor((x + 2^(SHIFT-1)) / 2^SHIFT), computed with plain integers.
  function automatic longint rnd(input logic [IW-1:0] x);
    longint v, d, n;
    v = longint'($signed(x));
    d = longint'(1) << SHIFT;
    n = v + d / 2;
    if (n >= 0) return n / d;
    else return -((-n + d - 1) / d);
  endfunction

  function automatic bit outside(input longint r);
    longint maxv, minv;
    maxv = (longint'(1) << (OW - 1)) - 1;
    minv = -(longint'(1) << (OW - 1));
    return (r > maxv) || (r < minv);
  endfunction

  function automatic logic [OW-1:0] toOut(input longint r);
    longint c;
    logic [63:0] t;
    c = r;
`ifdef FIRC_OUT_SAT_EN
    if (c > (longint'(1) << (OW - 1)) - 1) c = (longint'(1) << (OW - 1)) - 1;
    if (c < -(longint'(1) << (OW - 1))) c = -(longint'(1) << (OW - 1));
`endif
    t = c;
    return t[OW-1:0];
  endfunction

  task automatic clearModel();
    q.delete();
    pendV = 1'b0;
    pendD = '0;
    dropE = 0;
    ovfE  = 1'b0;
  endtask

  // Compare every output against the model for the current cycle.
  task automatic compare();
    logic expPush;
    logic [2*OW-1:0] head;
    expPush = (q.size() != 0) && !StopOut;
    chk("PushOut", PushOut, expPush);
    chk("Level", Level, q.size());
    chk("DropCnt", DropCnt, dropE);
    chk("Ovf", Ovf, ovfE);
    if (expPush) begin
      head = q[0];
      chk("OutI", OutI, head[2*OW-1:OW]);
      chk("OutQ", OutQ, head[OW-1:0]);
    end
  endtask

  // Advance the model across the coming rising edge, using the inputs now applied.
  task automatic modelStep();
    bit popNow;
    int sizeBefore;
    longint ri, rq;
    sizeBefore = q.size();
    popNow = (sizeBefore != 0) && !StopOut;
    if (popNow) void'(q.pop_front());
    if (pendV) begin
      if (sizeBefore < DEPTH || popNow) q.push_back(pendD);
      else if (dropE < 255) dropE++;
    end
    pendV = PushIn;
    if (PushIn) begin
      ri = rnd(FI);
      rq = rnd(FQ);
      pendD = {toOut(ri), toOut(rq)};
      if (outside(ri) || outside(rq)) ovfE = 1'b1;
    end
  endtask

  task automatic cycle(input logic pi, input logic [IW-1:0] fi, input logic [IW-1:0] fq, input logic so);
    @(posedge Clk);
    #1;
    PushIn = pi;
    FI = fi;
    FQ = fq;
    StopOut = so;
    @(negedge Clk);
    compare();
    modelStep();
  endtask

  task automatic resetDut();
    #2;
    Reset = 1'b1;
    PushIn = 1'b0;
    StopOut = 1'b0;
    #1;
    chk("rst PushOut", PushOut, 1'b0);
    chk("rst Level", Level, 0);
    chk("rst DropCnt", DropCnt, 0);
    chk("rst Ovf", Ovf, 1'b0);
    chk("rst OutI", OutI, 0);
    chk("rst OutQ", OutQ, 0);
    clearModel();
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  function automatic logic [IW-1:0] smallVal();
    logic [IW-1:0] v;
    v = IW'($urandom_range(0, 32'h00FF_FFFF)) - 32'h0080_0000;
    return v;
  endfunction

  initial begin
    logic [OW-1:0] expSat;
    Reset = 1'b1;
    PushIn = 1'b0;
    StopOut = 1'b0;
    FI = '0;
    FQ = '0;
    clearModel();
    #3;
    chk("init PushOut", PushOut, 1'b0);
    chk("init Level", Level, 0);
    chk("init DropCnt", DropCnt, 0);
    chk("init Ovf", Ovf, 1'b0);
    chk("init OutI", OutI, 0);
    chk("init OutQ", OutQ, 0);
    @(negedge Clk);
    Reset = 1'b0;

    // Rounding up from half, with two-cycle latency
    cycle(1'b1, 32'h0001_8000, 32'h0000_7FFF, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0);
    chk("t1 early PushOut", PushOut, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0);
    chk("t1 PushOut", PushOut, 1'b1);
    chk("t1 OutI", OutI, 16'h0002);
    chk("t1 OutQ", OutQ, 16'h0000);
    chk("t1 Ovf", Ovf, 1'b0);

    // Negative values
    cycle(1'b1, 32'hFFFF_7FFF, 32'hFFFF_8000, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0);
    chk("t2 OutI", OutI, 16'hFFFF);
    chk("t2 OutQ", OutQ, 16'h0000);

    // Overflow of the positive range
    cycle(1'b1, 32'h7FFF_FFFF, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0);
    chk("t3 Ovf", Ovf, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0);
`ifdef FIRC_OUT_SAT_EN
    expSat = 16'h7FFF;
`else
    expSat = 16'h8000;
`endif
    chk("t3 OutI", OutI, expSat);

    // Fill under StopOut: ten pushes, so two of them are dropped
    for (int k = 1; k <= 10; k++) cycle(1'b1, IW'(k) << SHIFT, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b1);
    chk("t4 Level", Level, 8);
    chk("t4 DropCnt", DropCnt, 2);

    // At full, a write and a pop in the same cycle is accepted
    cycle(1'b1, IW'(11) << SHIFT, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0);
    chk("t5 PushOut", PushOut, 1'b1);
    chk("t5 OutI1", OutI, 16'd1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0);
    chk("t5 Level", Level, 8);
    chk("t5 DropCnt", DropCnt, 2);
    chk("t4 OutI2", OutI, 16'd2);
    for (int k = 3; k <= 8; k++) begin
      cycle(1'b0, 32'h0, 32'h0, 1'b0);
      chk("t4 drain OutI", OutI, k);
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b0);
    chk("t5 OutI", OutI, 16'd11);
    cycle(1'b0, 32'h0, 32'h0, 1'b0);
    chk("t4 empty Level", Level, 0);
    chk("t4 empty PushOut", PushOut, 1'b0);

    // Random traffic, with periods of heavy backpressure
    for (int i = 0; i < 1500; i++) begin
      logic so;
      if ((i / 100) % 3 == 0) so = ($urandom_range(0, 9) < 9);
      else so = ($urandom_range(0, 9) < 4);
      if ($urandom_range(0, 9) < 8)
        cycle($urandom_range(0, 9) < 6, smallVal(), smallVal(), so);
      else
        cycle($urandom_range(0, 9) < 6, $urandom, $urandom, so);
    end

    // DropCnt holds at 255
    for (int i = 0; i < 300; i++) cycle(1'b1, smallVal(), smallVal(), 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b1);
    chk("sat DropCnt", DropCnt, 8'd255);
    chk("sat Level", Level, 8);

    // Assert Reset mid-drain at Level 5
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0);
    chk("t6 pre Level", Level, 5);
    chk("t6 pre PushOut", PushOut, 1'b1);
    resetDut();

    // Random traffic after reset; Ovf starts clear and is set only by rare large values
    for (int i = 0; i < 1500; i++) begin
      logic so;
      if ((i / 150) % 2 == 0) so = ($urandom_range(0, 9) < 3);
      else so = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 199) != 0)
        cycle($urandom_range(0, 9) < 5, smallVal(), smallVal(), so);
      else
        cycle(1'b1, $urandom, $urandom, so);
    end
    for (int i = 0; i < 12; i++) cycle(1'b0, 32'h0, 32'h0, 1'b0);
    chk("final Level", Level, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
